// File: rtl/pixel_averager_if.sv
// ============================================================================
// Module      : pixel_averager_if
// Description : Valid/ready pixel stream feeding the 2x2 pixel averager.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pixel_averager_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] pixel_in;
    logic             pixel_valid;
    logic             pixel_ready;

    modport master (
        output pixel_in,
        output pixel_valid,
        input  pixel_ready
    );

    modport slave (
        input  pixel_in,
        input  pixel_valid,
        output pixel_ready
    );
endinterface

`default_nettype wire

// File: rtl/pixel_averager.sv
// ============================================================================
// Module      : pixel_averager
// Description : Streams a raster-order square image and packs the floor mean
//               of every non-overlapping 2x2 block into a result register,
//               using a one-row buffer of partial block sums.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_averager #(
    parameter int IMG_SIDE = 28,
    parameter int WIDTH    = 8
) (
    input  wire logic                                              clk,
    input  wire logic                                              reset,
    input  wire logic                                              avg_go,
    pixel_averager_if.slave                                        pix,
    output logic                                                   busy,
    output logic [WIDTH*(IMG_SIDE/2)*(IMG_SIDE/2)-1:0]             averaged_pixels,
    output logic                                                   avg_done
);

    localparam int c_HALF               = IMG_SIDE / 2;
    localparam int c_AVERAGED_PIXELS_NR = c_HALF * c_HALF;
    localparam int c_CNT_W              = $clog2(IMG_SIDE);
    localparam int c_J_W                = c_CNT_W - 1;
    localparam int c_K_W                = $clog2(c_AVERAGED_PIXELS_NR);
    localparam int c_ACC_W              = WIDTH + 2;

    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(IMG_SIDE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 w_ready;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_start;
    logic                 w_xfer;
    logic                 w_at_last;

    logic [c_CNT_W-1:0]   r_row;
    logic [c_CNT_W-1:0]   r_col;
    logic [c_ACC_W-1:0]   r_acc [c_HALF];

    logic [c_J_W-1:0]     w_j;
    logic [c_J_W-1:0]     w_row_pair;
    logic [c_K_W-1:0]     w_k;
    logic                 w_first;
    logic                 w_fourth;
    logic [c_ACC_W-1:0]   w_acc_sel;
    logic [c_ACC_W-1:0]   w_sum;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (avg_go) begin
                    w_state_next = S_ACCUM;
                    w_start      = 1'b1;
                end
            end
            S_ACCUM: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
                if (pix.pixel_valid && w_at_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                // One-cycle completion state; afterwards behaves exactly as idle.
                w_done = 1'b1;
                if (avg_go) begin
                    w_state_next = S_ACCUM;
                    w_start      = 1'b1;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign pix.pixel_ready = w_ready;
    assign busy            = w_busy;
    assign avg_done        = w_done;

    assign w_xfer    = w_ready & pix.pixel_valid;
    assign w_at_last = (r_row == c_LAST) && (r_col == c_LAST);

    // ------------------------------------------------------------------
    // Raster position counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_start) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_xfer) begin
            if (r_col == c_LAST) begin
                r_col <= '0;
                r_row <= (r_row == c_LAST) ? '0 : r_row + c_CNT_W'(1);
            end else begin
                r_col <= r_col + c_CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Block addressing and partial sums
    // ------------------------------------------------------------------
    assign w_j        = r_col[c_CNT_W-1:1];
    assign w_row_pair = r_row[c_CNT_W-1:1];
    assign w_k        = c_K_W'(w_row_pair) * c_K_W'(c_HALF) + c_K_W'(w_j);
    assign w_first    = ~r_row[0] & ~r_col[0];
    assign w_fourth   =  r_row[0] &  r_col[0];
    assign w_acc_sel  = r_acc[w_j];
    assign w_sum      = w_acc_sel + c_ACC_W'(pix.pixel_in);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < c_HALF; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_start) begin
            for (int i = 0; i < c_HALF; i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_xfer) begin
            // The top-left pixel of a block restarts its column's partial sum.
            r_acc[w_j] <= w_first ? c_ACC_W'(pix.pixel_in) : w_sum;
        end
    end

    // ------------------------------------------------------------------
    // Result register: only the fourth pixel of a block writes its element
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            averaged_pixels <= '0;
        end else if (w_xfer && w_fourth) begin
            averaged_pixels[int'(w_k)*WIDTH +: WIDTH] <= w_sum[c_ACC_W-1:2];
        end
    end

endmodule

`default_nettype wire
